// File: rtl/conv1_window.sv
// 3x3 sliding-window generator over a raster pixel stream, two line buffers, valid-only windows.
// Optional start-of-frame input enabled by defining CONV1_WINDOW_SOF_EN.
module conv1_window #(
   parameter int IMG_W  = 28,
   parameter int IMG_H  = 28,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
`ifdef CONV1_WINDOW_SOF_EN
   input  logic              sof,
`endif
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              win_valid,
   output logic [DATA_W-1:0] data_out [0:8],
   output logic              frame_done
);

   localparam int CW = $clog2(IMG_W);
   localparam int RW = $clog2(IMG_H);
   localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

   logic [DATA_W-1:0] lb0 [IMG_W];
   logic [DATA_W-1:0] lb1 [IMG_W];

   logic [CW-1:0]     col, col_eff, col_nxt;
   logic [RW-1:0]     row, row_eff, row_nxt;
   logic              col_last, row_last, qualify;
   logic [DATA_W-1:0] top_px, mid_px;

   // A start-of-frame pixel overrides the counters so it is always treated as (0,0)
   always_comb begin
      col_eff = col;
      row_eff = row;
`ifdef CONV1_WINDOW_SOF_EN
      if (sof) begin
         col_eff = '0;
         row_eff = '0;
      end
`endif
   end

   always_comb begin
      col_last = (col_eff == COL_LAST);
      row_last = (row_eff == ROW_LAST);
      col_nxt  = col_last ? '0 : col_eff + 1'b1;
      row_nxt  = row_eff;
      if (col_last)
         row_nxt = row_last ? '0 : row_eff + 1'b1;
      qualify  = (row_eff >= RW'(2)) && (col_eff >= CW'(2));
      top_px   = lb0[col_eff];
      mid_px   = lb1[col_eff];
   end

   // Line-buffer storage is left unreset; row/col qualification masks stale data
   always_ff @(posedge clk) begin
      if (in_valid) begin
         lb0[col_eff] <= mid_px;
         lb1[col_eff] <= in_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         col <= '0;
         row <= '0;
      end else if (in_valid) begin
         col <= col_nxt;
         row <= row_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         win_valid  <= 1'b0;
         frame_done <= 1'b0;
         for (int i = 0; i < 9; i++)
            data_out[i] <= '0;
      end else begin
         win_valid  <= in_valid && qualify;
         frame_done <= in_valid && qualify && col_last && row_last;
         if (in_valid) begin
            for (int r = 0; r < 3; r++) begin
               data_out[r*3]   <= data_out[r*3+1];
               data_out[r*3+1] <= data_out[r*3+2];
            end
            data_out[2] <= top_px;
            data_out[5] <= mid_px;
            data_out[8] <= in_data;
         end
      end
   end

endmodule

// File: tb/tb_conv1_window.sv
// Directed table-driven bench for conv1_window (4x4 instance) plus a 28x28 random-frame instance.
module tb_conv1_window;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic [31:0] in_data;
   logic        sof;
   logic        win_valid;
   logic [31:0] data_out [0:8];
   logic        frame_done;

   logic        b_valid;
   logic [31:0] b_data;
   logic        b_sof;
   logic        b_wv;
   logic [31:0] b_out [0:8];
   logic        b_fd;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   conv1_window #(.IMG_W(4), .IMG_H(4), .DATA_W(32)) dut (
      .clk(clk), .rst_n(rst_n),
`ifdef CONV1_WINDOW_SOF_EN
      .sof(sof),
`endif
      .in_valid(in_valid), .in_data(in_data),
      .win_valid(win_valid), .data_out(data_out), .frame_done(frame_done));

   conv1_window #(.IMG_W(28), .IMG_H(28), .DATA_W(32)) dut_big (
      .clk(clk), .rst_n(rst_n),
`ifdef CONV1_WINDOW_SOF_EN
      .sof(b_sof),
`endif
      .in_valid(b_valid), .in_data(b_data),
      .win_valid(b_wv), .data_out(b_out), .frame_done(b_fd));

   typedef struct {
      logic [31:0] idx;
      logic        exp_wv;
      logic        exp_fd;
   } vec_t;

   vec_t tbl [16];

   task automatic cycle(input logic v, input logic [31:0] d, input logic s);
      in_valid = v;
      in_data  = d;
      sof      = s;
      @(posedge clk);
      #1;
   endtask

   task automatic chk_bit(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0b expected %0b", name, act, exp);
      end
   endtask

   // Window for a 4x4 frame whose bottom-right is pixel index p, frame values base+index
   task automatic chk_win(input string name, input logic [31:0] base, input int p);
      int r, c;
      logic [31:0] e;
      r = p / 4;
      c = p % 4;
      for (int k = 0; k < 9; k++) begin
         e = base + 32'((r - 2 + k / 3) * 4 + (c - 2 + k % 3));
         checks++;
         if (data_out[k] !== e) begin
            errors++;
            $display("FAIL %s[%0d]: got %0d expected %0d", name, k, data_out[k], e);
         end
      end
   endtask

   task automatic run_frame(input string name, input logic [31:0] base, input bit gaps,
                            input bit sof_first);
      for (int i = 0; i < 16; i++) begin
         cycle(1'b1, base + tbl[i].idx, sof_first && (i == 0));
         chk_bit({name, "_wv"}, win_valid, tbl[i].exp_wv);
         chk_bit({name, "_fd"}, frame_done, tbl[i].exp_fd);
         if (tbl[i].exp_wv)
            chk_win({name, "_win"}, base, i);
         if (gaps) begin
            cycle(1'b0, 32'hDEAD_BEEF, 1'b0);
            chk_bit({name, "_gap_wv"}, win_valid, 1'b0);
            chk_bit({name, "_gap_fd"}, frame_done, 1'b0);
            if (tbl[i].exp_wv)
               chk_win({name, "_hold"}, base, i);
         end
      end
   endtask

   task automatic chk_zero(input string name);
      chk_bit({name, "_wv"}, win_valid, 1'b0);
      chk_bit({name, "_fd"}, frame_done, 1'b0);
      for (int k = 0; k < 9; k++) begin
         checks++;
         if (data_out[k] !== 32'd0) begin
            errors++;
            $display("FAIL %s_data[%0d]: got %0d expected 0", name, k, data_out[k]);
         end
      end
   endtask

   task automatic big_frame();
      logic [31:0] pix [28*28];
      int wins, fds, p;
      bit ok;
      logic [31:0] e;
      wins = 0;
      fds  = 0;
      for (int i = 0; i < 28*28; i++)
         pix[i] = $urandom;
      for (int r = 0; r < 28; r++) begin
         for (int c = 0; c < 28; c++) begin
            b_valid = 1'b1;
            b_data  = pix[r*28 + c];
            @(posedge clk);
            #1;
            if (b_fd) fds++;
            if (b_wv) begin
               wins++;
               ok = 1'b1;
               for (int k = 0; k < 9; k++) begin
                  p = (r - 2 + k / 3) * 28 + (c - 2 + k % 3);
                  e = (r >= 2 && c >= 2) ? pix[p] : 32'hX;
                  if (b_out[k] !== e) ok = 1'b0;
               end
               checks++;
               if (!ok) begin
                  errors++;
                  $display("FAIL big_win r=%0d c=%0d: got br=%0h expected br=%0h",
                           r, c, b_out[8], pix[r*28 + c]);
               end
            end
            chk_bit("big_wv_pos", b_wv, (r >= 2 && c >= 2));
         end
      end
      b_valid = 1'b0;
      checks++;
      if (wins != 676) begin
         errors++;
         $display("FAIL big_count: got %0d expected 676", wins);
      end
      chk_bit("big_fd_last", b_fd, 1'b1);
      checks++;
      if (fds != 1) begin
         errors++;
         $display("FAIL big_fd_count: got %0d expected 1", fds);
      end
   endtask

   initial begin
      for (int i = 0; i < 16; i++)
         tbl[i] = '{idx: 32'(i), exp_wv: 1'b0, exp_fd: 1'b0};
      tbl[10].exp_wv = 1'b1;
      tbl[11].exp_wv = 1'b1;
      tbl[14].exp_wv = 1'b1;
      tbl[15].exp_wv = 1'b1;
      tbl[15].exp_fd = 1'b1;

      rst_n = 1'b0;
      in_valid = 1'b0; in_data = '0; sof = 1'b0;
      b_valid = 1'b0; b_data = '0; b_sof = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk_zero("reset");
      rst_n = 1'b1;
      cycle(1'b0, 32'd0, 1'b0);

      run_frame("cont", 32'd0, 1'b0, 1'b0);
      cycle(1'b0, 32'd0, 1'b0);
      chk_bit("idle_fd", frame_done, 1'b0);

      run_frame("gaps", 32'd0, 1'b1, 1'b0);

      run_frame("b2b_a", 32'd0, 1'b0, 1'b0);
      run_frame("b2b_b", 32'd100, 1'b0, 1'b0);

      for (int i = 0; i < 10; i++)
         cycle(1'b1, 32'(i), 1'b0);
      rst_n = 1'b0;
      #1;
      chk_zero("midrst");
      cycle(1'b1, 32'd77, 1'b0);
      chk_zero("midrst_held");
      rst_n = 1'b1;
      run_frame("postrst", 32'd0, 1'b0, 1'b0);

`ifdef CONV1_WINDOW_SOF_EN
      for (int i = 0; i < 7; i++) begin
         cycle(1'b1, 32'(i), 1'b0);
         chk_bit("abort_fd", frame_done, 1'b0);
         chk_bit("abort_wv", win_valid, 1'b0);
      end
      run_frame("sof", 32'd0, 1'b0, 1'b1);
`endif

      cycle(1'b0, 32'd0, 1'b0);
      big_frame();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
